// File: rtl/transpose_unit.sv
// transpose_unit: combinational transpose of an m x n matrix of 8-bit elements
// held in a fixed 5x5 frame. Returns the n x m transpose in the same frame, with
// all slots outside the result region forced to zero.
//
// Ports
//   clk         system clock; not used internally (shared datapath port list)
//   reset       asynchronous active-low reset; not used internally (no state)
//   m_in        input row count, legal 1..5
//   n_in        input column count, legal 1..5
//   matrix_in   packed input frame, element (r,c) at [(r*5+c)*8 +: 8]
//   m_out       result row count (n_in when valid, else 0)
//   n_out       result column count (m_in when valid, else 0)
//   matrix_out  packed result frame, same packing; zero outside result region
//   valid       both dimensions are in 1..5
module transpose_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   m_in,
  input  logic [2:0]   n_in,
  input  logic [199:0] matrix_in,
  output logic [2:0]   m_out,
  output logic [2:0]   n_out,
  output logic [199:0] matrix_out,
  output logic         valid
);

  localparam int unsigned Dim   = 5;
  localparam int unsigned ElemW = 8;

  // Thermometer decode: bit k set when k < count, so a dimension of 3 enables
  // indices 0..2. Counts above the frame saturate; they are rejected by valid.
  function automatic logic [Dim-1:0] therm(input logic [2:0] count);
    logic [Dim-1:0] mask;
    mask = '0;
    case (count)
      3'd0:    mask = 5'b00000;
      3'd1:    mask = 5'b00001;
      3'd2:    mask = 5'b00011;
      3'd3:    mask = 5'b00111;
      3'd4:    mask = 5'b01111;
      default: mask = 5'b11111;
    endcase
    return mask;
  endfunction

  logic           m_legal;
  logic           n_legal;
  logic [Dim-1:0] res_row_en;  // result rows in use (indexed by input column)
  logic [Dim-1:0] res_col_en;  // result columns in use (indexed by input row)

  assign m_legal = (m_in != 3'd0) && (m_in <= 3'd5);
  assign n_legal = (n_in != 3'd0) && (n_in <= 3'd5);
  assign valid   = m_legal && n_legal;

  // Gating the row enables with valid zeroes the whole frame on illegal input.
  assign res_row_en = valid ? therm(n_in) : '0;
  assign res_col_en = therm(m_in);

  assign m_out = valid ? n_in : 3'd0;
  assign n_out = valid ? m_in : 3'd0;

  // Result slot (i,j) takes input slot (j,i) when inside the n_in x m_in region.
  for (genvar i = 0; i < Dim; i++) begin : g_res_row
    for (genvar j = 0; j < Dim; j++) begin : g_res_col
      logic slot_en;
      assign slot_en = res_row_en[i] && res_col_en[j];
      assign matrix_out[(i*Dim+j)*ElemW +: ElemW] =
          slot_en ? matrix_in[(j*Dim+i)*ElemW +: ElemW] : '0;
    end
  end

  // clk and reset exist only for port-list uniformity with sibling units.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

endmodule

// File: tb/tb_transpose_unit.sv
module tb_transpose_unit;

  logic         clk;
  logic         reset;
  logic [2:0]   m_in;
  logic [2:0]   n_in;
  logic [199:0] matrix_in;
  logic [2:0]   m_out;
  logic [2:0]   n_out;
  logic [199:0] matrix_out;
  logic         valid;

  bit clk_run;
  int n_checks;
  int n_errors;

  transpose_unit u_dut (
    .clk        (clk),
    .reset      (reset),
    .m_in       (m_in),
    .n_in       (n_in),
    .matrix_in  (matrix_in),
    .m_out      (m_out),
    .n_out      (n_out),
    .matrix_out (matrix_out),
    .valid      (valid)
  );

  always #5 if (clk_run) clk = ~clk;

  function automatic logic [199:0] put(input logic [199:0] f, input int r, input int c,
                                       input logic [7:0] v);
    logic [199:0] t;
    t = f;
    t[(r*5+c)*8 +: 8] = v;
    return t;
  endfunction

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_v, input logic [2:0] exp_m,
                           input logic [2:0] exp_n, input logic [199:0] exp_mat);
    check({tag, ".valid"}, 200'(valid), 200'(exp_v));
    check({tag, ".m_out"}, 200'(m_out), 200'(exp_m));
    check({tag, ".n_out"}, 200'(n_out), 200'(exp_n));
    check({tag, ".matrix"}, matrix_out, exp_mat);
  endtask

  logic [199:0] in_f;
  logic [199:0] exp_f;

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk      = 1'b0;
    clk_run  = 1'b0;
    reset    = 1'b0;

    // 1x3, reset held low, clock stopped
    in_f = '0;
    in_f = put(in_f, 0, 0, 8'd1);
    in_f = put(in_f, 0, 1, 8'd2);
    in_f = put(in_f, 0, 2, 8'd3);
    m_in = 3'd1; n_in = 3'd3; matrix_in = in_f;
    #10;
    exp_f = '0;
    exp_f[0*8 +: 8]  = 8'd1;  // (0,0)
    exp_f[5*8 +: 8]  = 8'd2;  // (1,0)
    exp_f[10*8 +: 8] = 8'd3;  // (2,0)
    check_all("row1x3", 1'b1, 3'd3, 3'd1, exp_f);

    reset   = 1'b1;
    clk_run = 1'b1;

    // 5x5 full frame
    in_f  = '0;
    exp_f = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        in_f  = put(in_f, r, c, 8'(r*5+c+1));
        exp_f = put(exp_f, c, r, 8'(r*5+c+1));
      end
    end
    m_in = 3'd5; n_in = 3'd5; matrix_in = in_f;
    #3;
    check_all("full5x5", 1'b1, 3'd5, 3'd5, exp_f);
    check("full5x5.slot04", 200'(matrix_out[4*8 +: 8]), 200'(8'd21));
    check("full5x5.slot40", 200'(matrix_out[20*8 +: 8]), 200'(8'd5));

    // 2x3 with unused input slots filled with FF
    in_f = '1;
    in_f = put(in_f, 0, 0, 8'd1);
    in_f = put(in_f, 0, 1, 8'd2);
    in_f = put(in_f, 0, 2, 8'd3);
    in_f = put(in_f, 1, 0, 8'd4);
    in_f = put(in_f, 1, 1, 8'd5);
    in_f = put(in_f, 1, 2, 8'd6);
    m_in = 3'd2; n_in = 3'd3; matrix_in = in_f;
    #3;
    exp_f = '0;
    exp_f[0*8 +: 8]  = 8'd1;  // (0,0)
    exp_f[1*8 +: 8]  = 8'd4;  // (0,1)
    exp_f[5*8 +: 8]  = 8'd2;  // (1,0)
    exp_f[6*8 +: 8]  = 8'd5;  // (1,1)
    exp_f[10*8 +: 8] = 8'd3;  // (2,0)
    exp_f[11*8 +: 8] = 8'd6;  // (2,1)
    check_all("ff2x3", 1'b1, 3'd3, 3'd2, exp_f);

    // Illegal dimensions
    m_in = 3'd0; n_in = 3'd3; #3;
    check_all("m0", 1'b0, 3'd0, 3'd0, '0);
    m_in = 3'd3; n_in = 3'd6; #3;
    check_all("n6", 1'b0, 3'd0, 3'd0, '0);
    m_in = 3'd7; n_in = 3'd1; #3;
    check_all("m7", 1'b0, 3'd0, 3'd0, '0);
    m_in = 3'd5; n_in = 3'd0; #3;
    check_all("n0", 1'b0, 3'd0, 3'd0, '0);

    // 1x1, then wiggle reset and clk
    in_f = '1;
    in_f = put(in_f, 0, 0, 8'hAB);
    m_in = 3'd1; n_in = 3'd1; matrix_in = in_f;
    #3;
    exp_f = '0;
    exp_f[7:0] = 8'hAB;
    check_all("one1x1", 1'b1, 3'd1, 3'd1, exp_f);
    reset = 1'b0;
    #12;
    check_all("one1x1.rst_lo", 1'b1, 3'd1, 3'd1, exp_f);
    reset = 1'b1;
    #7;
    check_all("one1x1.rst_hi", 1'b1, 3'd1, 3'd1, exp_f);

    // 3x2 then 2x3 on the same data
    in_f = '0;
    in_f = put(in_f, 0, 0, 8'd1);
    in_f = put(in_f, 0, 1, 8'd2);
    in_f = put(in_f, 1, 0, 8'd3);
    in_f = put(in_f, 1, 1, 8'd4);
    in_f = put(in_f, 2, 0, 8'd5);
    in_f = put(in_f, 2, 1, 8'd6);
    m_in = 3'd3; n_in = 3'd2; matrix_in = in_f;
    #3;
    exp_f = '0;
    exp_f[0*8 +: 8] = 8'd1;  // (0,0)
    exp_f[1*8 +: 8] = 8'd3;  // (0,1)
    exp_f[2*8 +: 8] = 8'd5;  // (0,2)
    exp_f[5*8 +: 8] = 8'd2;  // (1,0)
    exp_f[6*8 +: 8] = 8'd4;  // (1,1)
    exp_f[7*8 +: 8] = 8'd6;  // (1,2)
    check_all("dim3x2", 1'b1, 3'd2, 3'd3, exp_f);

    m_in = 3'd2; n_in = 3'd3;
    #3;
    exp_f = '0;
    exp_f[0*8 +: 8]  = 8'd1;  // (0,0)
    exp_f[1*8 +: 8]  = 8'd3;  // (0,1)
    exp_f[5*8 +: 8]  = 8'd2;  // (1,0)
    exp_f[6*8 +: 8]  = 8'd4;  // (1,1)
    check_all("dim2x3", 1'b1, 3'd3, 3'd2, exp_f);

    // Simultaneous change of dimensions and data
    in_f = put('0, 0, 1, 8'h5A);
    m_in = 3'd1; n_in = 3'd2; matrix_in = in_f;
    #3;
    exp_f = '0;
    exp_f[5*8 +: 8] = 8'h5A;  // (1,0)
    check_all("dim1x2", 1'b1, 3'd2, 3'd1, exp_f);

    clk_run = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
